// File: rtl/l2_tcdm_pkg.sv
// Shared types and helpers for the L2 TCDM responder.
// Pure declarations, no logic.
// Optional bus-error reporting is selected with L2_TCDM_RESP_ERR_EN in the top level.
package l2_tcdm_pkg;

  // One response pipeline stage: what kind of response leaves the bank and when.
  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } resp_stage_t;

  // Read data returned for requests that miss the bank.
  localparam logic [31:0] L2_ERR_PATTERN = 32'hBADACCE5;

  // Byte offset into the bank -> word index. The caller truncates to the SRAM
  // index width, which also gives modulo-depth aliasing when no range check is done.
  function automatic logic [63:0] l2_word_index(input logic [63:0] offs,
                                                input int unsigned byte_shift);
    return offs >> byte_shift;
  endfunction

endpackage

// File: rtl/l2_tcdm_resp_pipe.sv
// Response shift register tracking in-flight TCDM responses in request order.
// Latency: DEPTH cycles from stage_i to stage_o.
// No backpressure: advances every cycle, cleared asynchronously by reset.
module l2_tcdm_resp_pipe
  import l2_tcdm_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  resp_stage_t stage_i,
  output resp_stage_t stage_o,
  output logic        busy_o
);

  resp_stage_t [DEPTH-1:0] stage_d;
  resp_stage_t [DEPTH-1:0] stage_q;

  // Next state: load the accepted request into stage 0, shift the rest down.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = stage_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops every in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q[DEPTH-1];

  // Busy while any stage still carries a response.
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/l2_tcdm_responder.sv
// TCDM slave endpoint driving one single-port L2 bank; macro L2_TCDM_RESP_ERR_EN enables bus errors.
// Latency: response MEM_LATENCY cycles after the grant, in order, one per cycle sustained.
// No backpressure: gnt_o follows req_i whenever out of reset.
module l2_tcdm_responder
  import l2_tcdm_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1C00_0000),
  parameter int unsigned           MEM_WORDS   = 16384,
  parameter int unsigned           MEM_LATENCY = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  input  logic [ADDR_WIDTH-1:0]          add_i,
  input  logic                           wen_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        be_i,
  output logic                           gnt_o,
  output logic                           r_valid_o,
  output logic [DATA_WIDTH-1:0]          r_rdata_o,
  output logic                           r_opc_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [$clog2(MEM_WORDS)-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        mem_be_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
  output logic                           busy_o
);

  localparam int unsigned BE_W       = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(BE_W);
  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);

  logic [ADDR_WIDTH-1:0] offs;
  logic                  in_range;
  logic                  accept;
  logic                  mem_acc;
  logic [DATA_WIDTH-1:0] err_data;
  resp_stage_t           stage_in;
  resp_stage_t           stage_last;

  // Unsigned wrap makes addresses below the base decode as huge offsets.
  assign offs = add_i - BASE_ADDR;

`ifdef L2_TCDM_RESP_ERR_EN
  // One extra bit so a bank covering the whole address space cannot overflow.
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS) << BYTE_SHIFT;
  assign in_range = ({1'b0, offs} < MEM_BYTES);
`else
  // Without error reporting every address aliases into the bank.
  assign in_range = 1'b1;
`endif

  assign gnt_o   = req_i & rst_ni;
  assign accept  = req_i & gnt_o;
  assign mem_acc = accept & in_range;

  // SRAM drive: pass the request straight through; buses idle at zero otherwise.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (mem_acc) begin
      mem_req_o   = 1'b1;
      mem_we_o    = ~wen_i;
      mem_addr_o  = IDX_W'(l2_word_index(64'(offs), BYTE_SHIFT));
      mem_wdata_o = wdata_i;
      mem_be_o    = be_i;
    end
  end

  // Every accepted request, error or not, enters the same pipeline to keep order.
  always_comb begin
    stage_in       = '0;
    stage_in.valid = accept;
    stage_in.err   = accept & ~in_range;
    stage_in.we    = accept & ~wen_i;
  end

  l2_tcdm_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) i_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stage_i (stage_in),
    .stage_o (stage_last),
    .busy_o  (busy_o)
  );

  // Error pattern repeated across the data bus, truncated for narrow buses.
  always_comb begin
    err_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      err_data[i] = L2_ERR_PATTERN[i % 32];
    end
  end

  // Response data mux: SRAM data for reads, pattern for errors, zero for writes.
  always_comb begin
    r_valid_o = stage_last.valid;
    r_rdata_o = '0;
    if (stage_last.valid) begin
      if (stage_last.err) begin
        r_rdata_o = err_data;
      end else if (!stage_last.we) begin
        r_rdata_o = mem_rdata_i;
      end
    end
  end

`ifdef L2_TCDM_RESP_ERR_EN
  assign r_opc_o = stage_last.valid & stage_last.err;
`else
  assign r_opc_o = 1'b0;
`endif

endmodule

// File: tb/tb_l2_tcdm_responder.sv
// Randomized scoreboard bench for l2_tcdm_responder with a behavioural SRAM.
// Expected responses are queued at issue time and checked by an independent monitor.
// Handles both builds of L2_TCDM_RESP_ERR_EN.
module tb_l2_tcdm_responder;

  localparam int          L    = 3;
  localparam int          MW   = 256;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, r_valid, r_opc, mem_req, mem_we, busy;
  logic [31:0] r_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  l2_tcdm_responder #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .BASE_ADDR (BASE),
    .MEM_WORDS (MW), .MEM_LATENCY (L)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n), .req_i (req), .add_i (add), .wen_i (wen),
    .wdata_i (wdata), .be_i (be), .gnt_o (gnt), .r_valid_o (r_valid),
    .r_rdata_o (r_rdata), .r_opc_o (r_opc), .mem_req_o (mem_req), .mem_we_o (mem_we),
    .mem_addr_o (mem_addr), .mem_wdata_o (mem_wdata), .mem_be_o (mem_be),
    .mem_rdata_i (mem_rdata), .busy_o (busy)
  );

  // Behavioural SRAM: byte-masked writes, read data after L cycles.
  logic [31:0] sram [MW];
  logic [31:0] rdp  [L];
  assign mem_rdata = rdp[L-1];

  always @(posedge clk) begin
    for (int i = L-1; i > 0; i--) rdp[i] <= rdp[i-1];
    rdp[0] <= 32'h0;
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rdp[0] <= sram[mem_addr];
      end
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    int          due;
    logic        opc;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [MW];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  exp_t        mon_e;
  logic        mon_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every response, flags late, missing or unexpected ones.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      mon_busy = (q.size() > 0) && (q[0].due < cyc + L);
      chk("busy", {31'b0, busy}, {31'b0, mon_busy});
      if (r_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got r_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("rsp_cycle", cyc, mon_e.due);
          chk("rsp_opc", {31'b0, r_opc}, {31'b0, mon_e.opc});
          chk("rsp_data", r_rdata, mon_e.data);
        end
      end else begin
        chk("idle_rdata", r_rdata, 32'h0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          mon_e = q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_rsp: got no r_valid expected response due cycle %0d", mon_e.due);
        end
      end
    end
  end

  // Drive one cycle of request inputs and predict the response from first principles.
  task automatic drive(input logic rq, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] be_v);
    logic [31:0] offs;
    logic        inr;
    int          widx;
    exp_t        e;
    @(negedge clk);
    req = rq; add = a; wen = w; wdata = d; be = be_v;
    offs = a - BASE;
`ifdef L2_TCDM_RESP_ERR_EN
    inr = offs < 32'(MW * 4);
`else
    inr = 1'b1;
`endif
    widx = int'((offs / 4) % 32'(MW));
    if (rq) begin
      e.due = cyc + L;
      if (!inr) begin
        e.opc = 1'b1; e.data = 32'hBADACCE5;
      end else if (!w) begin
        for (int b = 0; b < 4; b++)
          if (be_v[b]) ref_mem[widx][8*b +: 8] = d[8*b +: 8];
        e.opc = 1'b0; e.data = 32'h0;
      end else begin
        e.opc = 1'b0; e.data = ref_mem[widx];
      end
      q.push_back(e);
    end
    #1;
    chk("gnt", {31'b0, gnt}, {31'b0, rq});
    chk("mem_req", {31'b0, mem_req}, {31'b0, rq && inr});
    if (rq && inr) begin
      chk("mem_addr", {24'b0, mem_addr}, widx);
      chk("mem_we", {31'b0, mem_we}, {31'b0, !w});
      if (!w) begin
        chk("mem_wdata", mem_wdata, d);
        chk("mem_be", {28'b0, mem_be}, {28'b0, be_v});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // Reset state, with a request pending to prove grant is suppressed.
    req = 1'b1; add = BASE; wen = 1'b0; wdata = 32'hFFFFFFFF; be = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {31'b0, gnt}, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_r_valid", {31'b0, r_valid}, 32'h0);
    chk("rst_r_opc", {31'b0, r_opc}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_r_rdata", r_rdata, 32'h0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Fill the bank so model and SRAM agree on every word.
    for (int w = 0; w < MW; w++) drive(1'b1, BASE + 32'(4 * w), 1'b0, $urandom, 4'hF);

    // Write then immediate readback.
    drive(1'b1, BASE + 32'h10, 1'b0, 32'hDEADBEEF, 4'hF);
    drive(1'b1, BASE + 32'h10, 1'b1, 32'h0, 4'h0);
    // Partial write over a known word.
    drive(1'b1, BASE + 32'h20, 1'b0, 32'h11223344, 4'hF);
    drive(1'b1, BASE + 32'h20, 1'b0, 32'h0000AB00, 4'b0010);
    drive(1'b1, BASE + 32'h20, 1'b1, 32'h0, 4'h0);
    // Eight back-to-back reads, unaligned low bits and random be ignored.
    for (int i = 0; i < 8; i++)
      drive(1'b1, BASE + 32'(4 * i) + 32'(i % 4), 1'b1, $urandom, 4'($urandom));
    // Below-base read between two good reads.
    drive(1'b1, BASE + 32'h10, 1'b1, 32'h0, 4'hF);
    drive(1'b1, BASE - 32'h4, 1'b1, 32'h0, 4'hF);
    drive(1'b1, BASE + 32'h20, 1'b1, 32'h0, 4'hF);
    // Just past the bank end.
    drive(1'b1, BASE + 32'(MW * 4), 1'b0, 32'hA11A5ED0, 4'hF);
    drive(1'b1, BASE, 1'b1, 32'h0, 4'hF);
    repeat (2) drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);

    // Randomized mix of reads, writes, gaps and out-of-bank addresses.
    for (int n = 0; n < 500; n++) begin
      int          sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
      else if (sel == 1) a = BASE + 32'(MW * 4) + 32'(4 * $urandom_range(0, 7));
      else               a = BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
      drive($urandom_range(0, 4) != 0, a, 1'($urandom), $urandom, 4'($urandom));
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    repeat (L + 2) drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);

    // Reset with two reads in flight: responses must vanish at once.
    drive(1'b1, BASE + 32'h40, 1'b1, 32'h0, 4'hF);
    drive(1'b1, BASE + 32'h44, 1'b1, 32'h0, 4'hF);
    @(posedge clk);
    #1 req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_r_valid", {31'b0, r_valid}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    // First request after release is served normally; no stale responses appear.
    drive(1'b1, BASE + 32'h10, 1'b1, 32'h0, 4'hF);
    repeat (L + 4) drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending responses expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
